keypad_scan: RTL and testbench
==============================

# keypad_scan

Scans a 4×4 active-low key matrix by driving one column low at a time and sampling the row lines. Each detected key is debounced and reported as a 4-bit hex code with a one-cycle valid strobe. The block is the input-side counterpart of the multiplexed seven-segment display path: the display scans anodes outward, this block scans columns and reads rows inward. Its `key_code`/`key_valid` output feeds counter-load and display logic in the board top level.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per column slot; minimum 2.
- `DEBOUNCE_N`, default 4: consecutive matching row samples required to accept a press or a release; minimum 1.
- `REPEAT_DELAY`, default 100: samples from acceptance to first auto-repeat (used only with `KEYPAD_REPEAT_EN`).
- `REPEAT_RATE`, default 25: samples between subsequent auto-repeats (used only with `KEYPAD_REPEAT_EN`).
- `clk` in 1: the single system clock.
- `rst` in 1: synchronous, active-high reset.
- `KEY_ROW` in 4: raw row inputs, active-low, with pull-ups on the board; asynchronous to `clk`.
- `KEY_COL` out 4: column drive, one-hot-low.
- `key_code` out 4: last accepted key, equal to row_idx*4 + col_idx.
- `key_valid` out 1: one-cycle strobe; `key_code` is valid in the same cycle.
- `key_held` out 1: high while the accepted key remains pressed.

## Operation
- **Input sync:** `KEY_ROW` passes through a 2-flop synchronizer before any use.
- **Slot timer:** counts 0..SCAN_DIV-1 and wraps.
  - A *sample* is taken at count SCAN_DIV-1, the last cycle of the slot, so the rows have settled.
  - `KEY_COL` rotates 1110→1101→1011→0111→1110 at the wrap, but only in SCAN.
  - In all other states the column is frozen on the captured key's column.
- **Valid pattern:** the sampled rows contain exactly one 0. The row index is the position of that 0. All-ones or multiple zeros count as "no key".
- **FSM states:** SCAN, DEBOUNCE, PRESSED, RELEASE.
  - **SCAN:** on a sample with a valid pattern, capture col_idx and row_idx, clear the debounce count, and go to DEBOUNCE with the column frozen. Any other sample stays in SCAN.
  - **DEBOUNCE:** each sample is compared with the captured pattern.
    - Match: increment the count. When DEBOUNCE_N matches including the capture sample are reached, load `key_code`, pulse `key_valid`, and go to PRESSED.
    - Mismatch: return to SCAN. Rotation resumes at the following column.
  - **PRESSED:** `key_held`=1.
    - A sample with rows all-ones goes to RELEASE with the count at 1.
    - Any other sample stays in PRESSED, including other keys pressed in the same column.
  - **RELEASE:** `key_held` stays 1.
    - An all-ones sample increments the count. At DEBOUNCE_N, clear `key_held` and go to SCAN.
    - Any zero in a sample returns to PRESSED with no new `key_valid`.
- `key_code` holds its value until the next acceptance.
- When DEBOUNCE_N=1, the capture sample itself accepts the key: SCAN goes directly to PRESSED.

## Timing
- Reset values: `KEY_COL`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0, state SCAN, all counters 0, synchronizer flops all-ones.
- `rst` takes effect on the next edge from any state. A reset mid-debounce discards the capture.
- `key_valid` rises in the cycle after the accepting sample and lasts exactly 1 cycle.
- Press-to-strobe latency for a clean key, once its column is driven: 2 synchronizer cycles + DEBOUNCE_N samples × SCAN_DIV cycles, plus 1 cycle.
- Worst-case added latency is 3×SCAN_DIV cycles waiting for the key's column to come round.
- Release-to-`key_held`-low latency: DEBOUNCE_N×SCAN_DIV cycles, plus 1 cycle.

## Configuration
- **`KEYPAD_REPEAT_EN` defined:**
  - In PRESSED, a repeat counter counts samples.
  - After REPEAT_DELAY samples, `key_valid` pulses again with the unchanged `key_code`. Further pulses follow every REPEAT_RATE samples.
  - The counter clears on entry to PRESSED from DEBOUNCE. It holds while in RELEASE and resumes on a bounce back to PRESSED.
- **Not defined:** exactly one `key_valid` per accepted press. No repeat counter is synthesized.

## Structure
- Package `keypad_pkg`:
  - state enum `kp_state_t` (SCAN, DEBOUNCE, PRESSED, RELEASE)
  - `COL_RESET` = 4'b1110
  - `ROWS_IDLE` = 4'b1111
  - function `row_onehot_idx` returning {valid, idx[1:0]}
- Sub-module `keypad_slot_timer` owns the SCAN_DIV counter. It outputs a `sample` strobe and takes an `advance` enable that rotates `KEY_COL`.

## Test plan
Unless noted, benches use SCAN_DIV=4, DEBOUNCE_N=3, with matrix model rows pulled up.
- **Clean press:** hold row1/col2 closed for 20 samples → exactly one `key_valid` with `key_code`=4'h6. `key_held`=1 until 3 samples after release, then 0.
- **Bounce on press:** close row3/col0, open at the 2nd sample, re-close → the first attempt gives no strobe. Later acceptance gives `key_code`=4'hC once.
- **Ghost / double key:** rows 0 and 2 both low on col1 → no `key_valid`. `KEY_COL` keeps rotating.
- **Release bounce:** while PRESSED on key 4'h3, open for 2 samples, close, then open for 3 samples → no second strobe. `key_held` falls only after the final 3 open samples.
- **Reset mid-debounce:** assert `rst` after 1 matching sample of key 4'h9 → next cycle `KEY_COL`=1110, `key_code`=0, `key_held`=0. No strobe is ever emitted for that capture.
- **Repeat, `KEYPAD_REPEAT_EN` with REPEAT_DELAY=5, REPEAT_RATE=2:** hold key 4'hF for 12 samples after acceptance → `key_valid` at acceptance and at samples 5, 7, 9, 11, all with code F.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } kp_state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Returns {valid, idx}: valid only when exactly one row line is pulled low.
  function automatic logic [2:0] row_onehot_idx(input logic [3:0] rows);
    logic [2:0] r;
    r = 3'b000;
    case (rows)
      4'b1110: r = 3'b100;
      4'b1101: r = 3'b101;
      4'b1011: r = 3'b110;
      4'b0111: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Key report bundle from the scanner to counter-load / display logic.
interface keypad_scan_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (output key_code, key_valid, key_held);
  modport slave  (input  key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scan_slot_timer.sv
// Column slot timer: one sample strobe per SCAN_DIV cycles, one-hot-low column drive.
module keypad_slot_timer #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic       sample,
  output logic [1:0] col_idx,
  output logic [3:0] key_col
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt;

  assign sample  = (cnt == CNT_W'(SCAN_DIV - 1));
  assign key_col = ~(4'b0001 << col_idx);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      col_idx <= '0;
    end else begin
      cnt <= sample ? '0 : cnt + 1'b1;
      if (sample && advance) col_idx <= col_idx + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with debounce; define KEYPAD_REPEAT_EN for auto-repeat strobes.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_N   = 4,
  parameter int REPEAT_DELAY = 100,
  parameter int REPEAT_RATE  = 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    KEY_ROW,
  output logic [3:0]    KEY_COL,
  keypad_scan_if.master kp
);

  localparam int DB_W = $clog2(DEBOUNCE_N + 1);

  if (SCAN_DIV < 2 || DEBOUNCE_N < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("keypad_scan: parameter out of range");
  end

  kp_state_t       state, state_n;
  logic [DB_W-1:0] cnt, cnt_n;
  logic [3:0]      row_s1, row_s2;
  logic [1:0]      cap_row, col_idx;
  logic [3:0]      key_code, acc_code;
  logic            key_valid;
  logic            sample, advance, capture, accept, rep_fire;
  logic [2:0]      pat;
  logic            pat_valid, rows_idle;

  keypad_slot_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .sample  (sample),
    .col_idx (col_idx),
    .key_col (KEY_COL)
  );

  assign pat       = row_onehot_idx(row_s2);
  assign pat_valid = pat[2];
  assign rows_idle = (row_s2 == ROWS_IDLE);
  // The column is frozen outside SCAN, so col_idx is already the captured column.
  assign acc_code  = (state == SCAN) ? {pat[1:0], col_idx} : {cap_row, col_idx};

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    accept  = 1'b0;
    advance = 1'b0;
    if (sample) begin
      case (state)
        SCAN: begin
          if (pat_valid) begin
            capture = 1'b1;
            if (DEBOUNCE_N == 1) begin
              accept  = 1'b1;
              state_n = PRESSED;
            end else begin
              cnt_n   = DB_W'(1);
              state_n = DEBOUNCE;
            end
          end else begin
            advance = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (pat_valid && pat[1:0] == cap_row) begin
            if (cnt == DB_W'(DEBOUNCE_N - 1)) begin
              accept  = 1'b1;
              state_n = PRESSED;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            advance = 1'b1;
            state_n = SCAN;
          end
        end
        PRESSED: begin
          if (rows_idle) begin
            if (DEBOUNCE_N == 1) begin
              state_n = SCAN;
            end else begin
              cnt_n   = DB_W'(1);
              state_n = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (!rows_idle) begin
            state_n = PRESSED;
          end else if (cnt == DB_W'(DEBOUNCE_N - 1)) begin
            state_n = SCAN;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1    <= ROWS_IDLE;
      row_s2    <= ROWS_IDLE;
      state     <= SCAN;
      cnt       <= '0;
      cap_row   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      row_s1    <= KEY_ROW;
      row_s2    <= row_s1;
      state     <= state_n;
      cnt       <= cnt_n;
      if (capture) cap_row <= pat[1:0];
      if (accept)  key_code <= acc_code;
      key_valid <= accept | rep_fire;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_started, rep_tick;

  // First repeat waits REPEAT_DELAY samples, later ones REPEAT_RATE; RELEASE simply pauses the count.
  assign rep_tick = sample && (state == PRESSED) && !rows_idle;
  assign rep_fire = rep_tick && (rep_started ? (rep_cnt + 1'b1 == REP_W'(REPEAT_RATE))
                                             : (rep_cnt + 1'b1 == REP_W'(REPEAT_DELAY)));

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      rep_cnt     <= '0;
      rep_started <= 1'b0;
    end else if (rep_tick) begin
      if (rep_fire) begin
        rep_cnt     <= '0;
        rep_started <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign kp.key_code  = key_code;
  assign kp.key_valid = key_valid;
  assign kp.key_held  = (state == PRESSED) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a 4x4 matrix model (SCAN_DIV=4, DEBOUNCE_N=3).
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [15:0] pressed = '0;
  int          strobes = 0;
  int          checks  = 0;
  int          errors  = 0;
  int          base;

  keypad_scan_if kp ();

  keypad_scan #(
    .SCAN_DIV     (4),
    .DEBOUNCE_N   (3),
    .REPEAT_DELAY (5),
    .REPEAT_RATE  (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .KEY_ROW (key_row),
    .KEY_COL (key_col),
    .kp      (kp)
  );

  always #5 clk = ~clk;

  // Matrix with pull-ups: a closed key pulls its row low while its column is driven low.
  always_comb begin
    key_row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  always @(negedge clk) if (kp.key_valid) strobes++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [15:0] keys;
    int          exp_strobes;
    logic [3:0]  exp_code;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'h0040, 1, 4'h6};  // row1/col2
    vecs[1] = '{16'h0202, 0, 4'h0};  // rows 0 and 2 on col1: ghost
    vecs[2] = '{16'h1000, 1, 4'hC};  // row3/col0
    vecs[3] = '{16'h8000, 1, 4'hF};  // row3/col3
    vecs[4] = '{16'h0001, 1, 4'h0};  // row0/col0
    vecs[5] = '{16'h0088, 0, 4'h0};  // rows 0 and 1 on col3: ghost
    vecs[6] = '{16'h0024, 1, 4'h5};  // col1 is scanned before col2

    // Reset state
    do_reset();
    check("reset_col",   key_col, 4'b1110);
    check("reset_code",  kp.key_code, 4'h0);
    check("reset_valid", kp.key_valid, 1'b0);
    check("reset_held",  kp.key_held, 1'b0);

    // Ghost pattern on col1 must not stop the rotation
    pressed = 16'h0202;
    do_reset();
    step(4);  check("rot_col1", key_col, 4'b1101);
    step(4);  check("rot_col2", key_col, 4'b1011);
    step(4);  check("rot_col3", key_col, 4'b0111);
    step(4);  check("rot_col0", key_col, 4'b1110);
    step(4);  check("rot_col1b", key_col, 4'b1101);

    // Table: hold 8 samples, release, wait 8 samples
    for (int i = 0; i < 7; i++) begin
      pressed = vecs[i].keys;
      do_reset();
      base = strobes;
      step(32);
      check($sformatf("v%0d_held", i), kp.key_held, (vecs[i].exp_strobes != 0));
      pressed = '0;
      step(32);
      check($sformatf("v%0d_held_off", i), kp.key_held, 1'b0);
      check($sformatf("v%0d_strobes", i), strobes - base, vecs[i].exp_strobes);
      check($sformatf("v%0d_code", i), kp.key_code, vecs[i].exp_code);
    end

    // Bounce on press: key C opens at the 2nd sample, then re-closes
    pressed = 16'h1000;
    do_reset();
    base = strobes;
    step(4);
    pressed = '0;
    step(4);
    check("bounce_no_held", kp.key_held, 1'b0);
    check("bounce_col_adv", key_col, 4'b1101);
    pressed = 16'h1000;
    step(23);
    check("bounce_pre_strobe", kp.key_valid, 1'b0);
    check("bounce_no_early", strobes - base, 0);
    step(1);
    check("bounce_strobe", kp.key_valid, 1'b1);
    check("bounce_code", kp.key_code, 4'hC);
    step(1);
    check("bounce_strobe_end", kp.key_valid, 1'b0);
    pressed = '0;
    step(10);
    check("bounce_held_before", kp.key_held, 1'b1);
    step(1);
    check("bounce_held_fall", kp.key_held, 1'b0);
    check("bounce_strobes", strobes - base, 1);

    // Release bounce on key 3: open 2 samples, close, open 3 samples
    pressed = 16'h0008;
    do_reset();
    base = strobes;
    step(24);
    check("rb_strobe", kp.key_valid, 1'b1);
    check("rb_code", kp.key_code, 4'h3);
    pressed = '0;
    step(8);
    check("rb_held_open2", kp.key_held, 1'b1);
    pressed = 16'h0008;
    step(4);
    pressed = '0;
    step(11);
    check("rb_held_before", kp.key_held, 1'b1);
    step(1);
    check("rb_held_fall", kp.key_held, 1'b0);
    check("rb_strobes", strobes - base, 1);

    // Reset mid-debounce on key 9 after a prior acceptance of key 9
    pressed = 16'h0200;
    do_reset();
    base = strobes;
    step(16);
    check("rst_first_code", kp.key_code, 4'h9);
    pressed = '0;
    step(12);
    check("rst_first_released", kp.key_held, 1'b0);
    pressed = 16'h0200;
    step(8);
    check("rst_col_frozen", key_col, 4'b1101);
    rst = 1'b1;
    pressed = '0;
    step(1);
    check("rst_mid_col",   key_col, 4'b1110);
    check("rst_mid_code",  kp.key_code, 4'h0);
    check("rst_mid_held",  kp.key_held, 1'b0);
    check("rst_mid_valid", kp.key_valid, 1'b0);
    rst = 1'b0;
    step(40);
    check("rst_mid_strobes", strobes - base, 1);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: strobes at acceptance and at PRESSED samples 5, 7, 9, 11
    pressed = 16'h8000;
    do_reset();
    base = strobes;
    step(24);
    check("rep_accept", kp.key_valid, 1'b1);
    step(20);
    check("rep_first", kp.key_valid, 1'b1);
    check("rep_code", kp.key_code, 4'hF);
    step(29);
    check("rep_strobes", strobes - base, 5);
    pressed = '0;
    step(20);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
